// File: rtl/rs232_pkg.sv
// Shared constants and types for the RS232 echo master: register map,
// status bit positions, FSM states and index-width helpers.
package rs232_pkg;

  localparam logic [4:0] ADDR_RX   = 5'd0;
  localparam logic [4:0] ADDR_TX   = 5'd4;
  localparam logic [4:0] ADDR_STAT = 5'd8;

  localparam int STAT_RX_RDY = 7;
  localparam int STAT_TX_RDY = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_POLL,
    S_RX_READ,
    S_TX_POLL,
    S_TX_WRITE
  } state_t;

  // Counter must hold 0..n-1 while using the $clog2(n+1) width of the original design.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs232_echo_master_if.sv
// Avalon-MM bus between the echo master and the RS232 register slave.
interface rs232_echo_master_if;

  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/rs232_pkt_buf.sv
// Packet byte buffer; the read side maps the transmit index to LIFO or FIFO order.
module rs232_pkt_buf
  import rs232_pkg::*;
#(
  parameter int PKT_BYTES = 32,
  parameter bit REVERSE   = 1'b1,
  localparam int IW       = idx_width(PKT_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_BYTES - 1);

  logic [7:0]    mem_q [PKT_BYTES];
  logic [IW-1:0] rd_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_map  = REVERSE ? (LAST_IDX - rd_idx) : rd_idx;
  assign rd_data = mem_q[rd_map];

endmodule

// File: rtl/rs232_echo_master.sv
// Avalon-MM master that polls the RS232 slave, collects PKT_BYTES bytes and
// echoes them back (reversed when REVERSE=1).
module rs232_echo_master
  import rs232_pkg::*;
#(
  parameter int PKT_BYTES = 32,
  parameter bit REVERSE   = 1'b1
) (
  input  logic                avm_clk,
  input  logic                avm_rst_n,
  rs232_echo_master_if.master avm,
  input  logic                enable,
  output logic                busy,
  output logic                pkt_done
);

  localparam int CW = cnt_width(PKT_BYTES);
  localparam int IW = idx_width(PKT_BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_BYTES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [31:0]   writedata_q, writedata_d;
  logic          pkt_done_q, pkt_done_d;

  logic          rd_acc;
  logic          wr_acc;
  logic          buf_we;
  logic [7:0]    buf_rdata;

  assign rd_acc = read_q  && !avm.avm_waitrequest;
  assign wr_acc = write_q && !avm.avm_waitrequest;

  rs232_pkt_buf #(
    .PKT_BYTES (PKT_BYTES),
    .REVERSE   (REVERSE)
  ) u_buf (
    .clk     (avm_clk),
    .rst_n   (avm_rst_n),
    .wr_en   (buf_we),
    .wr_idx  (cnt_q[IW-1:0]),
    .wr_data (avm.avm_readdata[7:0]),
    .rd_idx  (cnt_q[IW-1:0]),
    .rd_data (buf_rdata)
  );

  // Bus request lines are registered; a new request is set up in the same
  // cycle the previous one is accepted so read can stay high back-to-back.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    pkt_done_d  = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_RX_POLL;
          read_d    = 1'b1;
          address_d = ADDR_STAT;
        end
      end

      S_RX_POLL: begin
        if (rd_acc && avm.avm_readdata[STAT_RX_RDY]) begin
          state_d   = S_RX_READ;
          address_d = ADDR_RX;
        end
      end

      S_RX_READ: begin
        if (rd_acc) begin
          buf_we    = 1'b1;
          address_d = ADDR_STAT;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_TX_POLL;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RX_POLL;
          end
        end
      end

      S_TX_POLL: begin
        if (rd_acc && avm.avm_readdata[STAT_TX_RDY]) begin
          state_d     = S_TX_WRITE;
          read_d      = 1'b0;
          write_d     = 1'b1;
          address_d   = ADDR_TX;
          writedata_d = {24'h000000, buf_rdata};
        end
      end

      S_TX_WRITE: begin
        if (wr_acc) begin
          write_d = 1'b0;
          if (cnt_q == LAST_CNT) begin
            cnt_d      = '0;
            pkt_done_d = 1'b1;
            state_d    = S_IDLE;
            address_d  = ADDR_RX;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            state_d   = S_TX_POLL;
            read_d    = 1'b1;
            address_d = ADDR_STAT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      address_q   <= 5'd0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= 32'h0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign avm.avm_address   = address_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = writedata_q;
  assign busy              = (state_q != S_IDLE);
  assign pkt_done          = pkt_done_q;

endmodule

// File: tb/tb_rs232_echo_master.sv
// Directed bench: a LIFO and a FIFO echo master run in lockstep against one
// behavioural RS232 slave; the slave logs every accepted transaction.
module tb_rs232_echo_master;
  import rs232_pkg::*;

  localparam int PKT = 4;

  logic avm_clk   = 1'b0;
  logic avm_rst_n = 1'b0;
  logic enable    = 1'b0;
  logic busy_r, busy_f, done_r, done_f;

  int checks   = 0;
  int failures = 0;

  always #5 avm_clk = ~avm_clk;

  rs232_echo_master_if bus_r ();
  rs232_echo_master_if bus_f ();

  rs232_echo_master #(.PKT_BYTES(PKT), .REVERSE(1'b1)) dut_r (
    .avm_clk   (avm_clk),
    .avm_rst_n (avm_rst_n),
    .avm       (bus_r.master),
    .enable    (enable),
    .busy      (busy_r),
    .pkt_done  (done_r)
  );

  rs232_echo_master #(.PKT_BYTES(PKT), .REVERSE(1'b0)) dut_f (
    .avm_clk   (avm_clk),
    .avm_rst_n (avm_rst_n),
    .avm       (bus_f.master),
    .enable    (enable),
    .busy      (busy_f),
    .pkt_done  (done_f)
  );

  // Slave model state. Both masters issue identical address/request sequences,
  // so one set of responses (keyed on the LIFO master) serves both.
  logic [7:0]  rx_src [64];
  int          poll_cnt  = 0;
  int          rx_idx    = 0;
  int          ready_at  = 0;
  int          done_cnt  = 0;
  int          proto_err = 0;
  logic        tx_rdy    = 1'b1;
  logic        stall_en  = 1'b0;
  logic [31:0] rdata;
  logic        wreq;
  logic [7:0]  log_r [$];
  logic [7:0]  log_f [$];
  int          wr_rxidx [$];
  int          rd0_poll [$];

  logic        prev_pend = 1'b0;
  logic [4:0]  prev_addr = 5'd0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_rd   = 1'b0;
  logic        prev_wr   = 1'b0;

  always_comb begin
    rdata = 32'h0;
    if (bus_r.avm_address == ADDR_STAT)
      rdata = {24'hFFFFFF, (poll_cnt >= ready_at), tx_rdy, 6'h3F};
    else if (bus_r.avm_address == ADDR_RX)
      rdata = {24'hDEADBE, rx_src[6'(rx_idx)]};
  end

  assign wreq                  = stall_en & bus_r.avm_write;
  assign bus_r.avm_readdata    = rdata;
  assign bus_r.avm_waitrequest = wreq;
  assign bus_f.avm_readdata    = rdata;
  assign bus_f.avm_waitrequest = wreq;

  always @(posedge avm_clk) begin
    if (bus_r.avm_read && !wreq) begin
      if (bus_r.avm_address == ADDR_STAT) begin
        poll_cnt <= poll_cnt + 1;
      end else if (bus_r.avm_address == ADDR_RX) begin
        rd0_poll.push_back(poll_cnt);
        rx_idx <= rx_idx + 1;
      end
    end
    if (bus_r.avm_write && !wreq) begin
      log_r.push_back(bus_r.avm_writedata[7:0]);
      wr_rxidx.push_back(rx_idx);
    end
    if (bus_f.avm_write && !wreq)
      log_f.push_back(bus_f.avm_writedata[7:0]);
    if (done_r)
      done_cnt <= done_cnt + 1;

    if (avm_rst_n) begin
      if ((bus_r.avm_read && bus_r.avm_write) ||
          ((bus_r.avm_read || bus_r.avm_write) &&
           !(bus_r.avm_address inside {ADDR_RX, ADDR_TX, ADDR_STAT})) ||
          (bus_r.avm_write && (bus_r.avm_address != ADDR_TX || bus_r.avm_writedata[31:8] != 24'h0)) ||
          (prev_pend && (bus_r.avm_address != prev_addr || bus_r.avm_writedata != prev_data ||
                         bus_r.avm_read != prev_rd || bus_r.avm_write != prev_wr)))
        proto_err <= proto_err + 1;
    end
    prev_pend <= (bus_r.avm_read || bus_r.avm_write) && wreq;
    prev_addr <= bus_r.avm_address;
    prev_data <= bus_r.avm_writedata;
    prev_rd   <= bus_r.avm_read;
    prev_wr   <= bus_r.avm_write;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic loadBytes(input logic [31:0] bytes);
    for (int i = 0; i < PKT; i++)
      rx_src[6'(rx_idx + i)] = bytes[8*i +: 8];
  endtask

  // bytes = {b3, b2, b1, b0}, b0 arrives first. One busy cycle elapses here.
  task automatic applyStimulus(input logic [31:0] bytes, input bit hold_en);
    loadBytes(bytes);
    enable = 1'b1;
    @(negedge avm_clk);
    enable = hold_en;
  endtask

  task automatic waitDone(input string tag, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge avm_clk);
      if (done_r) seen = 1'b1;
      else if (busy_r) busy_cycles++;
    end
    checkOutput({tag, " pkt_done seen"}, 32'(seen), 32'd1);
    if (seen) checkOutput({tag, " busy low at pkt_done"}, 32'(busy_r), 32'd0);
  endtask

  task automatic checkLogs(input string tag, input int base, input logic [31:0] bytes);
    logic [7:0] got;
    checkOutput({tag, " lifo write count"}, 32'(log_r.size() - base), 32'(PKT));
    checkOutput({tag, " fifo write count"}, 32'(log_f.size() - base), 32'(PKT));
    for (int i = 0; i < PKT; i++) begin
      got = (base + i < log_r.size()) ? log_r[base + i] : 8'hxx;
      checkOutput($sformatf("%s lifo byte %0d", tag, i), 32'(got), 32'(bytes[8*(PKT-1-i) +: 8]));
      got = (base + i < log_f.size()) ? log_f[base + i] : 8'hxx;
      checkOutput($sformatf("%s fifo byte %0d", tag, i), 32'(got), 32'(bytes[8*i +: 8]));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " address"},   32'(bus_r.avm_address), 32'd0);
    checkOutput({tag, " read"},      32'(bus_r.avm_read), 32'd0);
    checkOutput({tag, " write"},     32'(bus_r.avm_write), 32'd0);
    checkOutput({tag, " writedata"}, bus_r.avm_writedata, 32'd0);
    checkOutput({tag, " busy"},      32'(busy_r), 32'd0);
    checkOutput({tag, " pkt_done"},  32'(done_r), 32'd0);
    checkOutput({tag, " fifo dut outputs"},
                32'({busy_f, done_f, bus_f.avm_read, bus_f.avm_write, bus_f.avm_writedata[7:0]}), 32'd0);
  endtask

  task automatic checkIdle(input string tag, input int n);
    int act = 0;
    repeat (n) begin
      @(negedge avm_clk);
      if (bus_r.avm_read || bus_r.avm_write || busy_r || bus_f.avm_read || bus_f.avm_write || busy_f)
        act++;
    end
    checkOutput(tag, 32'(act), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  base_log, base_done, base_rx, poll_base, rd_base, busy_cycles, hi;
    bit  seen, stable;
    logic [4:0]  a0;
    logic [31:0] d0;

    repeat (2) @(negedge avm_clk);
    checkResetOutputs("reset");
    avm_rst_n = 1'b1;
    @(negedge avm_clk);

    // Packet 1: data ready at once, enable pulsed for one cycle only.
    base_log  = log_r.size();
    base_done = done_cnt;
    base_rx   = rx_idx;
    applyStimulus(32'h44332211, 1'b0);
    waitDone("p1", busy_cycles);
    checkOutput("p1 busy cycles after start", 32'(busy_cycles), 32'd15);
    checkLogs("p1", base_log, 32'h44332211);
    checkOutput("p1 first write after 4th rx read",
                32'((wr_rxidx.size() > base_log) ? wr_rxidx[base_log] : -1), 32'(base_rx + 4));
    checkIdle("p1 no activity after enable drop", 10);
    checkOutput("p1 pkt_done pulses", 32'(done_cnt - base_done), 32'd1);

    // Packet 2: RX not ready for 10 polls, TX busy for a while, first write stalled.
    base_log  = log_r.size();
    base_rx   = rx_idx;
    poll_base = poll_cnt;
    rd_base   = rd0_poll.size();
    ready_at  = poll_cnt + 10;
    tx_rdy    = 1'b0;
    stall_en  = 1'b1;
    applyStimulus(32'h3CC35AA5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge avm_clk);
      seen = (rx_idx == base_rx + 4);
    end
    checkOutput("p2 rx complete", 32'(seen), 32'd1);
    checkOutput("p2 status polls before first data read",
                32'((rd0_poll.size() > rd_base) ? rd0_poll[rd_base] - poll_base : -1), 32'd11);
    repeat (5) @(negedge avm_clk);
    checkOutput("p2 no write while tx not free", 32'(bus_r.avm_write), 32'd0);
    checkOutput("p2 tx status polling", 32'({bus_r.avm_read, bus_r.avm_address}), 32'({1'b1, ADDR_STAT}));
    tx_rdy = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge avm_clk);
      seen = bus_r.avm_write;
    end
    checkOutput("p2 write started", 32'(seen), 32'd1);
    a0 = bus_r.avm_address;
    d0 = bus_r.avm_writedata;
    hi = 1;
    stable = 1'b1;
    checkOutput("p2 stalled write address", 32'(a0), 32'(ADDR_TX));
    checkOutput("p2 stalled write data", d0, 32'h0000003C);
    for (int i = 0; i < 5; i++) begin
      @(negedge avm_clk);
      if (bus_r.avm_write) hi++;
      if (bus_r.avm_address != a0 || bus_r.avm_writedata != d0) stable = 1'b0;
    end
    checkOutput("p2 nothing accepted during stall", 32'(log_r.size() - base_log), 32'd0);
    stall_en = 1'b0;
    @(negedge avm_clk);
    if (bus_r.avm_write) hi++;
    checkOutput("p2 write high cycles", 32'(hi), 32'd6);
    checkOutput("p2 address and data stable", 32'(stable), 32'd1);
    checkOutput("p2 one byte accepted", 32'(log_r.size() - base_log), 32'd1);
    checkOutput("p2 cnt advanced once", 32'(dut_r.cnt_q), 32'd1);
    waitDone("p2", busy_cycles);
    checkLogs("p2", base_log, 32'h3CC35AA5);

    // Packet 3: reset after two bytes; restart must echo only fresh data.
    base_rx = rx_idx;
    applyStimulus(32'h04030201, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge avm_clk);
      seen = (rx_idx == base_rx + 2);
    end
    checkOutput("p3 two bytes received", 32'(seen), 32'd1);
    avm_rst_n = 1'b0;
    #1;
    checkResetOutputs("p3 async reset");
    repeat (2) @(negedge avm_clk);
    avm_rst_n = 1'b1;
    @(negedge avm_clk);

    base_log  = log_r.size();
    base_done = done_cnt;
    applyStimulus(32'h74737271, 1'b1);
    waitDone("p4", busy_cycles);
    checkOutput("p4 busy cycles after start", 32'(busy_cycles), 32'd15);
    checkLogs("p4 fresh packet", base_log, 32'h74737271);

    // enable still high: exactly one idle cycle before the next packet.
    loadBytes(32'h84838281);
    base_log = log_r.size();
    @(negedge avm_clk);
    checkOutput("p5 restart after one idle cycle", 32'(busy_r), 32'd1);
    enable = 1'b0;
    waitDone("p5", busy_cycles);
    checkOutput("p5 busy cycles after start", 32'(busy_cycles), 32'd15);
    checkLogs("p5", base_log, 32'h84838281);
    checkIdle("final idle", 20);
    checkOutput("p4/p5 pkt_done pulses", 32'(done_cnt - base_done), 32'd2);
    checkOutput("protocol violations", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
